// File: rtl/spec_packer.sv
// Packs four 16-bit channels per 64-bit word, frames each spectrum with a header,
// and buffers frames in a FWFT FIFO; spectra that cannot be fully reserved are dropped.
module spec_packer #(
    parameter int N_CHAN     = 2048,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        sync_in,
    input  logic [15:0] data_in,
    input  logic        overflow_in,
    output logic [63:0] m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [31:0] drop_count,
    output logic        running
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FRAME = N_CHAN / 4 + 1;
    localparam logic [AW+1:0] MAX_OCC = (AW+2)'(FIFO_DEPTH - FRAME);
    localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [11:0]   LAST_CH = 12'(N_CHAN - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;

    logic [11:0] chan_cnt;
    logic [51:0] spec_cnt;
    logic [11:0] ovf_acc, ovf_prev;
    logic [47:0] pack;
    logic        skip;

    logic [64:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] occupancy;
    logic          start, fits, hdr_wr, pay_wr, wr_en, rd_en;
    logic [64:0]   wr_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && ce && sync_in) state_next = RUN;
    end

    assign running = (state == RUN);

    // Occupancy includes the output register so the reservation covers every stored word.
    always_comb begin
        occupancy = {1'b0, count} + {{(AW+1){1'b0}}, m_valid};
        start     = running && ce && (chan_cnt == '0);
        fits      = (occupancy <= MAX_OCC);
        hdr_wr    = start && fits;
        pay_wr    = running && ce && (chan_cnt[1:0] == 2'b11) && !skip;
        wr_en     = hdr_wr || pay_wr;
        wr_word   = hdr_wr ? {1'b0, spec_cnt, ovf_prev}
                           : {(chan_cnt == LAST_CH), pack, data_in};
        rd_en     = (count != '0) && (!m_valid || m_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_cnt   <= '0;
            spec_cnt   <= '0;
            ovf_acc    <= '0;
            ovf_prev   <= '0;
            pack       <= '0;
            skip       <= 1'b0;
            drop_count <= '0;
        end else if (state == IDLE) begin
            if (ce && sync_in) chan_cnt <= '0;
        end else if (ce) begin
            chan_cnt <= (chan_cnt == LAST_CH) ? '0 : chan_cnt + 12'd1;
            case (chan_cnt[1:0])
                2'd0:    pack[47:32] <= data_in;
                2'd1:    pack[31:16] <= data_in;
                2'd2:    pack[15:0]  <= data_in;
                default: ;
            endcase
            if (chan_cnt == LAST_CH) begin
                ovf_prev <= ovf_acc + 12'(overflow_in);
                ovf_acc  <= '0;
            end else begin
                ovf_acc  <= ovf_acc + 12'(overflow_in);
            end
            if (start) begin
                spec_cnt <= spec_cnt + 52'd1;
                skip     <= !fits;
                if (!fits && drop_count != '1) drop_count <= drop_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (rd_en) begin
                m_valid          <= 1'b1;
                {m_last, m_data} <= mem[rd_ptr];
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && count == FULL));

endmodule

// File: tb/tb_spec_packer.sv
// Directed scoreboard bench for spec_packer with N_CHAN=16, FIFO_DEPTH=16.
module tb_spec_packer;
    localparam int NC = 16;
    localparam int FD = 16;

    localparam logic [63:0] W0 = 64'h0000010102020303;
    localparam logic [63:0] W1 = 64'h0404050506060707;
    localparam logic [63:0] W2 = 64'h080809090A0A0B0B;
    localparam logic [63:0] W3 = 64'h0C0C0D0D0E0E0F0F;

    logic        clk = 1'b0;
    logic        rst_n, ce, sync_in, overflow_in, m_ready;
    logic [15:0] data_in;
    logic [63:0] m_data;
    logic        m_valid, m_last, running;
    logic [31:0] drop_count;

    int          checks = 0;
    int          passes = 0;
    logic [64:0] expq[$];
    logic [64:0] mon_exp;

    spec_packer #(.N_CHAN(NC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sync_in(sync_in), .data_in(data_in),
        .overflow_in(overflow_in), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .drop_count(drop_count), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (expq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got %h expected none", {m_last, m_data});
            end else begin
                mon_exp = expq.pop_front();
                check("out_word", {m_last, m_data}, mon_exp);
            end
        end
    end

    task automatic cyc(input logic c, input logic s, input logic [15:0] d, input logic o);
        ce = c; sync_in = s; data_in = d; overflow_in = o;
        @(posedge clk); #1;
    endtask

    task automatic push_frame(input logic [63:0] hdr);
        expq.push_back({1'b0, hdr});
        expq.push_back({1'b0, W0});
        expq.push_back({1'b0, W1});
        expq.push_back({1'b0, W2});
        expq.push_back({1'b1, W3});
    endtask

    task automatic send_spectrum(input logic [63:0] hdr, input bit accept,
                                 input logic [15:0] ovf_mask, input int gap, input bit lat);
        if (accept) push_frame(hdr);
        for (int ch = 0; ch < NC; ch++) begin
            repeat (gap) cyc(1'b0, 1'b1, 16'hFFFF, 1'b1);
            cyc(1'b1, 1'b0, 16'(ch * 257), ovf_mask[ch]);
            if (lat && ch == 0) check("hdr_lat_edge1_valid", 65'(m_valid), 65'd0);
            if (lat && ch == 1) begin
                check("hdr_lat_edge2_valid", 65'(m_valid), 65'd1);
                check("hdr_lat_edge2_data", 65'(m_data), 65'(hdr));
            end
        end
    endtask

    task automatic drain(input string name);
        int  n;
        logic ok;
        n  = 0;
        ce = 1'b0; sync_in = 1'b0; overflow_in = 1'b0;
        while ((expq.size() != 0 || m_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (expq.size() == 0) && !m_valid;
        check(name, 65'(ok), 65'd1);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; sync_in = 1'b0; data_in = '0; overflow_in = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 65'(m_valid), 65'd0);
        check("reset_drop", 65'(drop_count), 65'd0);
        check("reset_running", 65'(running), 65'd0);
        rst_n = 1'b1;
        repeat (5) cyc(1'b1, 1'b0, 16'hABCD, 1'b1);
        check("idle_valid", 65'(m_valid), 65'd0);
        check("idle_running", 65'(running), 65'd0);

        cyc(1'b1, 1'b1, 16'h0000, 1'b0);
        check("run_after_sync", 65'(running), 65'd1);
        send_spectrum(64'h0, 1'b1, 16'h0000, 0, 1'b1);
        drain("drain_single");

        send_spectrum(64'h1000, 1'b1, 16'h0000, 2, 1'b0);
        drain("drain_gaps");

        send_spectrum(64'h2000, 1'b1, 16'h8084, 0, 1'b0);
        send_spectrum(64'h3003, 1'b1, 16'h0000, 0, 1'b0);
        send_spectrum(64'h4000, 1'b1, 16'h0000, 0, 1'b0);
        drain("drain_ovf");

        m_ready = 1'b0;
        send_spectrum(64'h5000, 1'b1, 16'h0000, 0, 1'b0);
        send_spectrum(64'h6000, 1'b1, 16'h0000, 0, 1'b0);
        send_spectrum(64'h7000, 1'b1, 16'h0000, 0, 1'b0);
        check("drop_before_full", 65'(drop_count), 65'd0);
        check("stall_hold_data", {m_last, m_data}, {1'b0, 64'h5000});
        check("stall_valid", 65'(m_valid), 65'd1);
        send_spectrum(64'h8000, 1'b0, 16'h0000, 0, 1'b0);
        check("drop_after_full", 65'(drop_count), 65'd1);
        m_ready = 1'b1;
        drain("drain_backpressure");
        send_spectrum(64'h9000, 1'b1, 16'h0000, 0, 1'b0);
        drain("drain_after_drop");

        m_ready = 1'b0;
        for (int ch = 0; ch < 9; ch++) cyc(1'b1, 1'b0, 16'(ch * 257), 1'b1);
        ce = 1'b1; data_in = 16'h0909;
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid", 65'(m_valid), 65'd0);
        check("midrst_drop", 65'(drop_count), 65'd0);
        check("midrst_running", 65'(running), 65'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (5) cyc(1'b1, 1'b0, 16'h1234, 1'b0);
        check("midrst_fifo_empty", 65'(m_valid), 65'd0);
        cyc(1'b1, 1'b1, 16'h0000, 1'b0);
        send_spectrum(64'h0, 1'b1, 16'h0000, 0, 1'b0);
        drain("drain_restart");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
